// File: rtl/mult_div_sequencer.sv
// Iterative multiply/divide engine for the LC-3X EX stage.
// Shift-add multiply and restoring divide, one bit per clock.
module mult_div_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 op_q, op_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_sh;
  logic [WIDTH-1:0]     div_diff;

  // One iteration: acc = {hi, lo}; lo holds multiplier or dividend/quotient
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh[WIDTH-1:0] - opnd_q;
    if (op_q) begin
      if (div_sh >= {1'b0, opnd_q})
        acc_step = {div_diff, acc_q[WIDTH-2:0], 1'b1};
      else
        acc_step = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sequencer next-state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    res_d   = res_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d = RUN;
          cnt_d   = CW'(WIDTH);
          op_d    = op_div;
          opnd_d  = op_div ? src_b : src_a;
          acc_d   = {{WIDTH{1'b0}}, op_div ? src_a : src_b};
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            res_d   = acc_step[WIDTH-1:0];
            rem_d   = acc_step[2*WIDTH-1:WIDTH];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
    end
  end

  // A flush in the DONE cycle squashes the pulse
  always_comb begin
    done      = (state_q == DONE) && !flush;
    stall     = start && !done && !flush;
    result    = res_q;
    remainder = rem_q;
  end

endmodule
